// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and a status bundle
// used by monitors and scoreboards that watch a sync_fifo_thresh.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF      = 8;

    typedef struct packed {
        logic full;
        logic empty;
        logic almostfull;
        logic almostempty;
        logic overflow;
        logic underflow;
        logic wr_ack;
    } fifo_status_t;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Simple dual-port storage for sync_fifo_thresh: synchronous write,
// registered read. Array contents are never reset; only the read
// register clears so the FIFO output starts at a known zero.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
    parameter int DEPTH      = FIFO_DEPTH_DEF,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Store write data; the array itself carries no reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; holds its value when no read is accepted.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : fifo_mem

// File: rtl/sync_fifo_thresh.sv
// Parametrised single-clock FIFO with runtime-programmable almost-full /
// almost-empty thresholds and a live fill level.
// Optional high-watermark register enabled by defining FIFO_PEAK_LEVEL_EN;
// without it peak_level reads 0 and peak_clr is ignored.
module sync_fifo_thresh
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
    parameter int DEPTH      = FIFO_DEPTH_DEF,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [ADDR_WIDTH:0]   level,
    output logic [ADDR_WIDTH:0]   peak_level,
    input  logic                  peak_clr
);

    localparam logic [ADDR_WIDTH:0]   LVL_MAX = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LVL_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_mem_we;
    logic w_mem_re;

    assign w_full   = (r_count == LVL_MAX);
    assign w_empty  = (r_count == '0);
    // Acceptance uses pre-edge state: a read at full and a write at empty
    // both succeed, but an empty FIFO never reads through a same-cycle write.
    assign w_wr_acc = wr_en && !w_full;
    assign w_rd_acc = rd_en && !w_empty;
    // Requests are ignored while reset is asserted.
    assign w_mem_we = rst_n && w_wr_acc;
    assign w_mem_re = rst_n && w_rd_acc;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_re    (w_mem_re),
        .i_raddr (r_rd_ptr),
        .o_rdata (data_out)
    );

    // Pointers, occupancy count and the one-cycle handshake/error pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + LVL_ONE;
            end else if (!w_wr_acc && w_rd_acc) begin
                r_count <= r_count - LVL_ONE;
            end
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= wr_en && w_full;
            r_underflow <= rd_en && w_empty;
        end
    end

    assign wr_ack      = r_wr_ack;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign full        = w_full;
    assign empty       = w_empty;
    assign level       = r_count;
    // A zero almost-full threshold disables the flag; thresholds above
    // DEPTH can never be reached below full, so they disable it too.
    assign almostfull  = (af_thresh != '0) && (r_count >= af_thresh) && !w_full;
    assign almostempty = !w_empty && (r_count <= ae_thresh);

`ifdef FIFO_PEAK_LEVEL_EN
    logic [ADDR_WIDTH:0] r_peak;

    // High-watermark of the registered count; a clear reloads the current level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_peak <= '0;
        end else if (peak_clr) begin
            r_peak <= r_count;
        end else if (r_count > r_peak) begin
            r_peak <= r_count;
        end
    end

    assign peak_level = r_peak;
`else
    logic w_unused_peak_clr;

    assign w_unused_peak_clr = peak_clr;
    assign peak_level        = '0;
`endif

endmodule : sync_fifo_thresh

// File: tb/tb_sync_fifo_thresh.sv
// Bench for sync_fifo_thresh (DEPTH=8, DATA_WIDTH=16). The driver pushes the
// expected post-edge response of every cycle into a queue; a monitor on the
// falling edge pops and compares. Directed spot checks with hand-computed
// constants follow the key steps. Honours FIFO_PEAK_LEVEL_EN like the design.
module tb_sync_fifo_thresh;
    import fifo_pkg::*;

    localparam int DW = 16;
    localparam int DEPTH = 8;

    typedef struct {
        fifo_status_t st;
        logic [3:0]   lvl;
        logic [15:0]  dout;
        logic [3:0]   peak;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  af_thresh = 4'd6;
    logic [3:0]  ae_thresh = 4'd2;
    logic        peak_clr = 1'b0;
    logic [15:0] data_out;
    logic        wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
    logic [3:0]  level;
    logic [3:0]  peak_level;

    int n_cmp = 0;
    int n_err = 0;

    exp_t        exp_q[$];
    logic [15:0] mq[$];
    logic [15:0] m_dout = '0;
    logic [3:0]  m_peak = '0;

    sync_fifo_thresh #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_in     (data_in),
        .af_thresh   (af_thresh),
        .ae_thresh   (ae_thresh),
        .data_out    (data_out),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .underflow   (underflow),
        .full        (full),
        .empty       (empty),
        .almostfull  (almostfull),
        .almostempty (almostempty),
        .level       (level),
        .peak_level  (peak_level),
        .peak_clr    (peak_clr)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: apply inputs, derive the expected post-edge
    // response from the queue model, hand it to the monitor after the edge.
    task automatic step(input logic w, input logic r, input logic [15:0] d,
                        input logic rn = 1'b1, input logic pc = 1'b0);
        exp_t e;
        int   pre;
        logic pre_full, pre_empty, acc_w, acc_r, ack, ov, un;
        wr_en = w; rd_en = r; data_in = d; rst_n = rn; peak_clr = pc;
        pre = mq.size();
        pre_full = (pre == DEPTH);
        pre_empty = (pre == 0);
        if (!rn) begin
            mq.delete();
            m_dout = '0; ack = 0; ov = 0; un = 0; m_peak = '0;
        end else begin
            acc_w = w && !pre_full;
            acc_r = r && !pre_empty;
            ack = acc_w; ov = w && pre_full; un = r && pre_empty;
            if (acc_r) m_dout = mq.pop_front();
            if (acc_w) mq.push_back(d);
            if (pc) m_peak = 4'(pre);
            else if (4'(pre) > m_peak) m_peak = 4'(pre);
        end
        e.lvl = 4'(mq.size());
        e.st.full = (mq.size() == DEPTH);
        e.st.empty = (mq.size() == 0);
        e.st.almostfull = (af_thresh != 0) && (e.lvl >= af_thresh) && !e.st.full;
        e.st.almostempty = !e.st.empty && (e.lvl <= ae_thresh);
        e.st.overflow = ov;
        e.st.underflow = un;
        e.st.wr_ack = ack;
        e.dout = m_dout;
`ifdef FIFO_PEAK_LEVEL_EN
        e.peak = m_peak;
`else
        e.peak = '0;
`endif
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
        #1;
        wr_en = 0; rd_en = 0; peak_clr = 0;
    endtask

    // Monitor: the DUT presents a new response every cycle after an edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            fifo_status_t act;
            e = exp_q.pop_front();
            act = '{full: full, empty: empty, almostfull: almostfull,
                    almostempty: almostempty, overflow: overflow,
                    underflow: underflow, wr_ack: wr_ack};
            cmp("sb_status", 32'(act), 32'(e.st));
            cmp("sb_level", 32'(level), 32'(e.lvl));
            cmp("sb_data_out", 32'(data_out), 32'(e.dout));
            cmp("sb_peak", 32'(peak_level), 32'(e.peak));
        end
    end

    initial begin
        // Reset, then reset mid-traffic at level 5.
        step(0, 0, 16'h0, 1'b0);
        step(0, 0, 16'h0, 1'b0);
        cmp("rst_empty", 32'(empty), 1);
        cmp("rst_level", 32'(level), 0);
        for (int i = 0; i < 5; i++) step(1, 0, 16'h00A0 + 16'(i));
        cmp("pre_rst_level", 32'(level), 5);
        step(1, 1, 16'h00FF, 1'b0);
        step(1, 1, 16'h00FF, 1'b0);
        cmp("midrst_level", 32'(level), 0);
        cmp("midrst_empty", 32'(empty), 1);
        cmp("midrst_full", 32'(full), 0);
        cmp("midrst_ae", 32'(almostempty), 0);
        cmp("midrst_af", 32'(almostfull), 0);
        cmp("midrst_pulses", 32'({wr_ack, overflow, underflow}), 0);
        cmp("midrst_dout", 32'(data_out), 0);

        // Fill 1..8 with af=6, ae=2, then one rejected write.
        af_thresh = 4'd6; ae_thresh = 4'd2;
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 16'(i));
            cmp("fill_wr_ack", 32'(wr_ack), 1);
            if (i <= 2) cmp("fill_ae_on", 32'(almostempty), 1);
            if (i == 3) cmp("fill_ae_off", 32'(almostempty), 0);
            if (i == 5) cmp("fill_af_off", 32'(almostfull), 0);
            if (i == 6 || i == 7) cmp("fill_af_on", 32'(almostfull), 1);
        end
        cmp("fill_full", 32'(full), 1);
        cmp("fill_af_at_full", 32'(almostfull), 0);
        step(1, 0, 16'h0009);
        cmp("ovf_flag", 32'(overflow), 1);
        cmp("ovf_wr_ack", 32'(wr_ack), 0);
        cmp("ovf_level", 32'(level), 8);

        // Threshold boundaries while full / level 7.
        af_thresh = 4'd9;
        #1 cmp("af_gt_depth", 32'(almostfull), 0);

        // Drain 8 in order, then one rejected read.
        af_thresh = 4'd6;
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 16'h0);
            cmp("drain_data", 32'(data_out), i);
        end
        step(0, 1, 16'h0);
        cmp("udf_flag", 32'(underflow), 1);
        cmp("udf_hold", 32'(data_out), 16'h0008);
        cmp("udf_empty", 32'(empty), 1);

        // Concurrent read/write at level 4 for 20 cycles; pointers wrap.
        for (int i = 0; i < 4; i++) step(1, 0, 16'h0100 + 16'(i));
        for (int i = 0; i < 20; i++) step(1, 1, 16'h0200 + 16'(i));
        cmp("rw_level", 32'(level), 4);
        for (int i = 0; i < 4; i++) step(0, 1, 16'h0);
        cmp("rw_last_data", 32'(data_out), 16'h0213);

        // Concurrent at full: read only.
        for (int i = 0; i < 8; i++) step(1, 0, 16'h0300 + 16'(i));
        af_thresh = 4'd0;
        step(1, 1, 16'h0399);
        cmp("full_rw_level", 32'(level), 7);
        cmp("full_rw_ovf", 32'(overflow), 1);
        cmp("full_rw_data", 32'(data_out), 16'h0300);
        cmp("af_zero", 32'(almostfull), 0);
        af_thresh = 4'd6;
        for (int i = 0; i < 7; i++) step(0, 1, 16'h0);
        // Concurrent at empty: write only, no read-through.
        step(1, 1, 16'h0400);
        cmp("empty_rw_level", 32'(level), 1);
        cmp("empty_rw_udf", 32'(underflow), 1);
        cmp("empty_rw_ack", 32'(wr_ack), 1);
        cmp("empty_rw_data", 32'(data_out), 16'h0307);

        // High-watermark: fill to 7, drain to 2, then clear.
        step(0, 0, 16'h0, 1'b0);
        for (int i = 0; i < 7; i++) step(1, 0, 16'h0500 + 16'(i));
        for (int i = 0; i < 5; i++) step(0, 1, 16'h0);
        step(0, 0, 16'h0);
`ifdef FIFO_PEAK_LEVEL_EN
        cmp("peak_hold", 32'(peak_level), 7);
`else
        cmp("peak_hold", 32'(peak_level), 0);
`endif
        step(0, 0, 16'h0, 1'b1, 1'b1);
        step(0, 0, 16'h0);
`ifdef FIFO_PEAK_LEVEL_EN
        cmp("peak_clr", 32'(peak_level), 2);
`else
        cmp("peak_clr", 32'(peak_level), 0);
`endif

        // Let the monitor consume everything, bounded.
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        cmp("sb_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sync_fifo_thresh

// File: doc/sync_fifo_thresh.md
Name: sync_fifo_thresh

Overview:
Parametrised synchronous FIFO, successor to the fixed-size FIFO. Width and depth are generic. Almost-full and almost-empty thresholds are programmable at runtime, and a live fill level is exported. Drop-in buffer between producer and consumer stages in the same clock domain, driven through the team's FIFO interface.

Parameters:
DATA_WIDTH, 16, width of data_in / data_out
DEPTH, 8, number of entries; power of two, >= 4
ADDR_WIDTH, $clog2(DEPTH), localparam; pointer width (count/level width = ADDR_WIDTH+1)

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
wr_en  in  1  write request
rd_en  in  1  read request
data_in  in  DATA_WIDTH  write data
af_thresh  in  ADDR_WIDTH+1  almost-full threshold (level)
ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold (level)
data_out  out  DATA_WIDTH  registered read data
wr_ack  out  1  registered; write accepted last cycle
overflow  out  1  registered; write rejected (full) last cycle
underflow  out  1  registered; read rejected (empty) last cycle
full  out  1  level == DEPTH
empty  out  1  level == 0
almostfull  out  1  threshold flag, see Behaviour
almostempty  out  1  threshold flag, see Behaviour
level  out  ADDR_WIDTH+1  current occupancy (count)
peak_level  out  ADDR_WIDTH+1  high-watermark (optional feature)
peak_clr  in  1  clear high-watermark (optional feature)

Behaviour:
- Reset is synchronous and active-low: on a clk edge with rst_n=0, wr_ptr=0, rd_ptr=0, count=0, data_out=0, wr_ack=0, overflow=0, underflow=0. Resulting flags: full=0, empty=1, almostfull=0, almostempty=0, level=0.
- Memory contents are not reset. wr_en and rd_en are ignored while rst_n=0. Reset mid-operation discards all stored data.
- Write accepted iff wr_en && !full: mem[wr_ptr]<=data_in, wr_ptr++ (wraps DEPTH-1 -> 0), wr_ack<=1 on the next edge, else wr_ack<=0.
- Read accepted iff rd_en && !empty: data_out<=mem[rd_ptr], rd_ptr++ (wraps). Latency is 1 cycle from the rd_en edge. data_out holds when no read is accepted.
- overflow<=wr_en && full; underflow<=rd_en && empty. Both are single-cycle registered pulses, evaluated on pre-edge state.
- Simultaneous wr_en && rd_en:
  - Neither full nor empty: both accepted, count unchanged.
  - Full: read only; write rejected and overflow=1.
  - Empty: write only; read rejected and underflow=1, no read-through.
- count updates: +1 on write only, -1 on read only, unchanged on both or neither. Range 0..DEPTH.
- Flags are combinational from the registered count and the threshold inputs:
  - almostfull = (af_thresh != 0) && (count >= af_thresh) && !full
  - almostempty = !empty && (count <= ae_thresh)
  - Thresholds may change at any cycle; flags follow combinationally.
- Threshold values > DEPTH are legal. With af_thresh > DEPTH, almostfull never asserts.

Optional Feature:
Macro FIFO_PEAK_LEVEL_EN.
- Defined: peak_level register, reset to 0. Each cycle, if peak_clr then peak_level<=count, else if count>peak_level then peak_level<=count.
- Undefined: peak_level tied to 0, peak_clr ignored, no extra flops.
- Port list is identical in both builds.

Decomposition:
- Package fifo_pkg holds:
  - Default constants: FIFO_DATA_WIDTH_DEF=16, FIFO_DEPTH_DEF=8.
  - typedef fifo_status_t: packed struct {full, empty, almostfull, almostempty, overflow, underflow, wr_ack} for monitors and scoreboards.
- One sub-module, fifo_mem: simple dual-port array with synchronous write and registered read, parametrised DATA_WIDTH/DEPTH. Pointer, count, flag and peak logic stay in sync_fifo_thresh.

Test Plan:
All cases use DEPTH=8, DATA_WIDTH=16.
1. rst_n=0 for 2 edges mid-traffic (count=5) -> next cycle level=0, empty=1, full=0, almostfull=0, almostempty=0, wr_ack=overflow=underflow=0.
2. af_thresh=6, ae_thresh=2; write 0x0001..0x0008 -> almostempty=1 at level 1..2; almostfull=1 at levels 6-7; full=1 at level 8; wr_ack high after each of the 8 writes. A 9th write -> overflow=1, wr_ack=0, level stays 8.
3. Read 8 times -> data_out 0x0001..0x0008 in order, each 1 cycle after rd_en. A 9th read -> underflow=1, data_out holds 0x0008, empty=1.
4. Hold wr_en=rd_en=1 for 20 cycles at level 4 -> level stays 4; pointers wrap; data order preserved, checked by scoreboard.
5. Simultaneous wr_en/rd_en at full -> read only, overflow=1, level 7. At empty -> write only, underflow=1, level 1.
6. With FIFO_PEAK_LEVEL_EN: fill to 7, drain to 2 -> peak_level=7. Pulse peak_clr -> peak_level=2. Without the macro -> peak_level=0 throughout.
